// File: rtl/string_palindrome_ctrl_if.sv
// Symbol stream in and result stream out of the palindrome sequencer.
// Both streams: a beat transfers on a rising clk where valid && ready; the sender holds its payload stable until then.
`timescale 1ns/1ps
interface string_palindrome_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic              res_palindrome;
    logic [LEN_W-1:0]  res_len;
    logic              res_overflow;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_palindrome, res_len, res_overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_palindrome, res_len, res_overflow
    );
endinterface

// File: rtl/string_palindrome_ctrl.sv
// Buffers a symbol string, then walks front/back pointers one pair per cycle
// to decide whether it is a palindrome; one result per string.
`timescale 1ns/1ps
module string_palindrome_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    string_palindrome_ctrl_if.slave  bus,
    output logic                     busy,
    output logic [1:0]               o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_RESULT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_count;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_hi;
    logic [DATA_W-1:0] r_buf [DEPTH];
    logic              r_pal;
    logic [LEN_W-1:0]  r_len;
    logic              r_res_ovf;

    logic w_accept;
    logic w_full;
    logic w_ovf_end;
    logic w_done;
    logic w_pair_eq;

    assign w_accept  = bus.in_valid && (r_state == S_LOAD);
    assign w_full    = (r_count == LEN_W'(DEPTH));
    assign w_ovf_end = r_ovf || w_full;
    assign w_done    = (r_lo >= r_hi);
    assign w_pair_eq = (r_buf[r_lo] == r_buf[r_hi]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_LOAD;
            S_LOAD:   if (w_accept && bus.in_last) w_next = w_ovf_end ? S_RESULT : S_CHECK;
            S_CHECK:  if (w_done || !w_pair_eq) w_next = S_RESULT;
            S_RESULT: if (bus.res_ready) w_next = S_LOAD;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_pal     <= 1'b0;
            r_len     <= '0;
            r_res_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (!w_full) r_count <= r_count + 1'b1;
                        else         r_ovf   <= 1'b1;
                        if (bus.in_last) begin
                            if (w_ovf_end) begin
                                r_pal     <= 1'b0;
                                r_len     <= LEN_W'(DEPTH);
                                r_res_ovf <= 1'b1;
                            end else begin
                                // The last symbol lands at index r_count, so that is hi.
                                r_lo <= '0;
                                r_hi <= r_count[ADDR_W-1:0];
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_done || !w_pair_eq) begin
                        r_pal     <= w_done;
                        r_len     <= r_count;
                        r_res_ovf <= 1'b0;
                    end else begin
                        r_lo <= r_lo + 1'b1;
                        r_hi <= r_hi - 1'b1;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer is pure storage; only symbols below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_accept && !w_full) r_buf[r_count[ADDR_W-1:0]] <= bus.in_data;
    end

    assign bus.in_ready       = (r_state == S_LOAD);
    assign bus.res_valid      = (r_state == S_RESULT);
    assign bus.res_palindrome = r_pal;
    assign bus.res_len        = r_len;
    assign bus.res_overflow   = r_res_ovf;
    assign busy               = (r_state == S_CHECK) || (r_state == S_RESULT);
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_string_palindrome_ctrl.sv
// Directed bench for string_palindrome_ctrl: string-level model, scoreboard and literal pins.
`timescale 1ns/1ps
module tb_string_palindrome_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int W      = 15;  // {pal, ovf, len[4:0], check_cycles[7:0]}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  string_palindrome_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  string_palindrome_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: string-level result of a buffered string
  logic [7:0] cur_s [0:31];

  function automatic logic [W-1:0] model(input int n);
    logic       pal;
    logic       ovf;
    logic [4:0] len;
    int         chk;
    ovf = (n > DEPTH);
    len = ovf ? 5'(DEPTH) : 5'(n);
    pal = !ovf;
    chk = ovf ? 0 : n / 2 + 1;
    if (!ovf) begin
      for (int k = 0; k < n / 2; k++) begin
        if (pal && cur_s[k] != cur_s[n - 1 - k]) begin
          pal = 1'b0;
          chk = k + 1;
        end
      end
    end
    return {pal, ovf, len, chk[7:0]};
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  int         chk_run = 0;
  bit         seen = 0;
  int         n_results = 0;
  logic       last_pal = 0;
  logic       last_ovf = 0;
  logic [4:0] last_len = 0;
  int         last_chk = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_run = 0;
      seen = 0;
    end else begin
      if (busy) check("in_ready_low_when_busy", 32'(bus.in_ready), 0);
      if (busy && !bus.res_valid) chk_run++;
      if (bus.res_valid) begin
        check("busy_with_result", 32'(busy), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: res_valid=1 with no string outstanding");
        end else begin
          check("res_palindrome", 32'(bus.res_palindrome), 32'(exp_q[0][14]));
          check("res_overflow", 32'(bus.res_overflow), 32'(exp_q[0][13]));
          check("res_len", 32'(bus.res_len), 32'(exp_q[0][12:8]));
          if (!seen) begin
            check("check_cycles", chk_run, 32'(exp_q[0][7:0]));
            last_chk = chk_run;
          end
          seen = 1;
          if (bus.res_ready) begin
            last_pal = bus.res_palindrome;
            last_ovf = bus.res_overflow;
            last_len = bus.res_len;
            void'(exp_q.pop_front());
            n_results++;
            chk_run = 0;
            seen = 0;
          end
        end
      end
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic send(input int n, input bit hold);
    int budget;
    exp_q.push_back(model(n));
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = cur_s[i];
      bus.in_last  = (i == n - 1);
      budget = 0;
      @(negedge clk);
      while (!bus.in_ready && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: beat %0d not accepted, in_ready=0 expected 1", i);
      end
      @(posedge clk); #1;
    end
    bus.in_last  = 1'b0;
    bus.in_valid = hold;
    if (hold) bus.in_data = 8'h55;
  endtask

  task automatic wait_result(input int target);
    int budget = 0;
    while (n_results < target && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check("result_arrived", 32'(n_results >= target), 1);
  endtask

  task automatic pin(input string tag, input logic pal, input logic [4:0] len, input logic ovf, input int chk);
    check({tag, "_pal"}, 32'(last_pal), 32'(pal));
    check({tag, "_len"}, 32'(last_len), 32'(len));
    check({tag, "_ovf"}, 32'(last_ovf), 32'(ovf));
    check({tag, "_cycles"}, last_chk, chk);
  endtask

  initial begin
    int budget;
    int got;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.res_ready = 1'b1;

    #2;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_len", 32'(bus.res_len), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("load_in_ready", 32'(bus.in_ready), 1);

    // odd palindrome
    cur_s[0] = 8'h41; cur_s[1] = 8'h42; cur_s[2] = 8'h41;
    send(3, 0);
    wait_result(1);
    pin("odd_pal", 1'b1, 5'd3, 1'b0, 2);

    // early mismatch at pair 1
    cur_s[0] = 8'h41; cur_s[1] = 8'h42; cur_s[2] = 8'h43; cur_s[3] = 8'h41;
    send(4, 0);
    wait_result(2);
    pin("mismatch", 1'b0, 5'd4, 1'b0, 2);

    // single symbol
    cur_s[0] = 8'h7E;
    send(1, 0);
    wait_result(3);
    pin("single", 1'b1, 5'd1, 1'b0, 1);

    // even palindrome
    cur_s[0] = 8'h01; cur_s[1] = 8'h02; cur_s[2] = 8'h02; cur_s[3] = 8'h01;
    send(4, 0);
    wait_result(4);
    pin("even_pal", 1'b1, 5'd4, 1'b0, 3);

    // no case folding
    cur_s[0] = 8'h61; cur_s[1] = 8'h41;
    send(2, 0);
    wait_result(5);
    pin("case", 1'b0, 5'd2, 1'b0, 1);

    // overflow: 17 beats
    for (int i = 0; i < 17; i++) cur_s[i] = 8'(i + 1);
    send(17, 0);
    wait_result(6);
    pin("overflow", 1'b0, 5'd16, 1'b1, 0);

    // full-buffer palindrome with backpressure and in_valid held high
    for (int i = 0; i < 8; i++) begin
      cur_s[i] = 8'(i * 3 + 1);
      cur_s[15 - i] = 8'(i * 3 + 1);
    end
    bus.res_ready = 1'b0;
    send(16, 1);
    budget = 0;
    @(negedge clk);
    while (!bus.res_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("stall_result_seen", 32'(bus.res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.res_valid), 1);
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    check("ready_after_handshake", 32'(bus.in_ready), 1);
    check("hold_pal", 32'(bus.res_palindrome), 1);
    check("hold_len", 32'(bus.res_len), 16);
    pin("full", 1'b1, 5'd16, 1'b0, 9);

    // reset in the middle of CHECK
    send(16, 0);
    got = n_results;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    check("midrst_res_valid", 32'(bus.res_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pal", 32'(bus.res_palindrome), 0);
    check("midrst_len", 32'(bus.res_len), 0);
    check("midrst_ovf", 32'(bus.res_overflow), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("midrst_load_ready", 32'(bus.in_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    check("no_result_after_reset", n_results, got);

    // recovery after the aborted string
    cur_s[0] = 8'h41; cur_s[1] = 8'h42; cur_s[2] = 8'h42; cur_s[3] = 8'h41; cur_s[4] = 8'h43;
    send(5, 0);
    wait_result(got + 1);
    pin("recover", 1'b0, 5'd5, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
